// File: rtl/issue_sched_pkg.sv
// Shared types and sizes for the 4-wide issue scheduler and its free list.
package issue_sched_pkg;

    localparam int LANES   = 4;
    localparam int DES_W   = 4;
    localparam int SRC_W   = 4;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic             vld;
        logic [DES_W-1:0] des;
        logic [SRC_W-1:0] src1;
        logic [SRC_W-1:0] src2;
    } lane_t;

    // Length of the unbroken run of ones starting at bit 0.
    function automatic logic [2:0] lead_ones(input logic [LANES-1:0] q);
        logic [2:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            run = run & q[k];
            if (run) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/issue_free_list.sv
// Busy bitmap for the in-flight table: picks the four lowest free entries,
// applies allocations and writebacks, and reports occupancy by popcount.
module issue_free_list
    import issue_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic [2:0]             alloc_cnt,
    input  logic [LANES-1:0]       wb_vld,
    input  logic [LANES*TAG_W-1:0] wb_tag,
    output logic [LANES*TAG_W-1:0] pick_tag,
    output logic [TAG_W:0]         free_cnt,
    output logic [TAG_W:0]         occ
);

    logic [ENTRIES-1:0] busy_reg;
    logic [ENTRIES-1:0] busy_next;
    logic [ENTRIES-1:0] alloc_mask;
    logic [ENTRIES-1:0] free_mask;
    logic [2:0]         found;

    // Priority picker: lowest free indices fill lane slots in order.
    always_comb begin
        pick_tag = '0;
        found    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!busy_reg[i] && found < 3'(LANES)) begin
                pick_tag[found*TAG_W +: TAG_W] = TAG_W'(i);
                found = found + 3'd1;
            end
        end
    end

    // Masks of entries taken and released this cycle; duplicates collapse naturally.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (3'(k) < alloc_cnt) begin
                alloc_mask[pick_tag[k*TAG_W +: TAG_W]] = 1'b1;
            end
            if (wb_vld[k]) begin
                free_mask[wb_tag[k*TAG_W +: TAG_W]] = 1'b1;
            end
        end
        busy_next = clear ? '0 : ((busy_reg & ~free_mask) | alloc_mask);
    end

    // Busy bitmap register; a freed entry becomes pickable only next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Occupancy as popcount of the bitmap, so it can never wrap.
    always_comb begin
        occ = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ = occ + (TAG_W+1)'(busy_reg[i]);
        end
        free_cnt = (TAG_W+1)'(ENTRIES) - occ;
    end

endmodule

// File: rtl/issue_scheduler.sv
// 4-wide in-order issue controller: accepts the longest hazard-free prefix of
// the decoded bundle, allocates in-flight tags, and sequences drain and flush.
// Optional stall counter enabled by defining ISSUE_SCHED_STATS_EN.
module issue_scheduler
    import issue_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       dec_vld,
    input  logic [LANES*DES_W-1:0] dec_des,
    input  logic [LANES*SRC_W-1:0] dec_src1,
    input  logic [LANES*SRC_W-1:0] dec_src2,
    input  logic [LANES-1:0]       hazard,
    output logic [2:0]             dec_acc,
    output logic [LANES-1:0]       iss_vld,
    output logic [LANES*TAG_W-1:0] iss_tag,
    output logic [LANES*DES_W-1:0] iss_des,
    input  logic [LANES-1:0]       wb_vld,
    input  logic [LANES*TAG_W-1:0] wb_tag,
    input  logic                   flush,
    input  logic                   drain_req,
    output logic                   drain_done,
    output logic [TAG_W:0]         occ,
`ifdef ISSUE_SCHED_STATS_EN
    output logic [31:0]            stall_cycles,
`endif
    output logic                   full
);

    sched_state_e state_reg, state_next;

    lane_t                   lanes [LANES];
    logic [LANES-1:0]        qual;
    logic [2:0]              lead;
    logic [2:0]              acc_cap;
    logic                    accept_en;
    logic [LANES*TAG_W-1:0]  pick_tag;
    logic [TAG_W:0]          free_cnt;
    logic [LANES-1:0]        iss_vld_reg;
    logic [LANES*TAG_W-1:0]  iss_tag_reg;
    logic [LANES*DES_W-1:0]  iss_des_reg;

    // Per-lane qualification: valid, no external hazard, no RAW on an older valid lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic raw_hit;

        assign lanes[gi] = '{vld:  dec_vld[gi],
                             des:  dec_des[gi*DES_W +: DES_W],
                             src1: dec_src1[gi*SRC_W +: SRC_W],
                             src2: dec_src2[gi*SRC_W +: SRC_W]};

        // Intra-bundle RAW against every earlier valid lane.
        always_comb begin
            raw_hit = 1'b0;
            for (int j = 0; j < gi; j++) begin
                if (lanes[j].vld &&
                    (lanes[gi].src1 == lanes[j].des || lanes[gi].src2 == lanes[j].des)) begin
                    raw_hit = 1'b1;
                end
            end
        end

        assign qual[gi] = lanes[gi].vld && !hazard[gi] && !raw_hit;
    end

    // Leading qualifying lanes, limited by the free entries seen this cycle.
    always_comb begin
        lead    = lead_ones(qual);
        acc_cap = ({2'b00, lead} > free_cnt) ? free_cnt[2:0] : lead;
        dec_acc = accept_en ? acc_cap : 3'd0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and state-decoded controls; flush wins in every state, and a
    // drain request stops acceptance in the very cycle it is raised.
    always_comb begin
        state_next = state_reg;
        accept_en  = 1'b0;
        drain_done = 1'b0;
        case (state_reg)
            RUN: begin
                accept_en = !flush && !drain_req;
                if (flush) begin
                    state_next = FLUSH;
                end else if (drain_req) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                drain_done = (occ == '0);
                if (flush) begin
                    state_next = FLUSH;
                end else if (!drain_req) begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                state_next = flush ? FLUSH : RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    issue_free_list u_free_list (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .alloc_cnt (dec_acc),
        .wb_vld    (wb_vld),
        .wb_tag    (wb_tag),
        .pick_tag  (pick_tag),
        .free_cnt  (free_cnt),
        .occ       (occ)
    );

    // Issue registers: accepted lanes carry their tag and destination, others are zeroed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_vld_reg <= '0;
            iss_tag_reg <= '0;
            iss_des_reg <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                iss_vld_reg[k]                 <= (3'(k) < dec_acc);
                iss_tag_reg[k*TAG_W +: TAG_W]  <= (3'(k) < dec_acc) ? pick_tag[k*TAG_W +: TAG_W] : '0;
                iss_des_reg[k*DES_W +: DES_W]  <= (3'(k) < dec_acc) ? dec_des[k*DES_W +: DES_W] : '0;
            end
        end
    end

    assign iss_vld = iss_vld_reg;
    assign iss_tag = iss_tag_reg;
    assign iss_des = iss_des_reg;
    assign full    = (occ == (TAG_W+1)'(ENTRIES));

`ifdef ISSUE_SCHED_STATS_EN
    logic [31:0] stall_reg;

    // Saturating count of RUN cycles where the oldest lane was offered but nothing issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_reg <= '0;
        end else if (dec_vld[0] && state_reg == RUN && dec_acc == 3'd0 && stall_reg != '1) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule
